// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential 32-bit mult/multu/div/divu unit with HI/LO registers.
module muldiv_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  op_q;
  logic [31:0] a_raw, d;
  logic [63:0] acc;
  logic        sa, sb;
  logic [31:0] a_mag, b_mag, q_f, r_f, hi_fix, lo_fix;
  logic [32:0] sum, trial;
  logic [63:0] next_acc, prod;
  logic        neg_q, neg_r, dz;
  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    a_mag    = (~op[0] & operand_a[31]) ? -operand_a : operand_a;
    b_mag    = (~op[0] & operand_b[31]) ? -operand_b : operand_b;
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, d} : 33'd0);
    trial    = acc[63:31] - {1'b0, d};
    next_acc = op_q[1] ? (trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1})
                       : {sum, acc[31:1]};
    neg_q    = ~op_q[0] & (sa ^ sb);
    neg_r    = ~op_q[0] & sa;
    dz       = op_q[1] & (d == 32'd0);
    prod     = neg_q ? -acc : acc;
    q_f      = neg_q ? -acc[31:0] : acc[31:0];
    r_f      = neg_r ? -acc[63:32] : acc[63:32];
    hi_fix   = op_q[1] ? (dz ? a_raw : r_f) : prod[63:32];
    lo_fix   = op_q[1] ? (dz ? 32'hFFFF_FFFF : q_f) : prod[31:0];
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      op_q        <= 2'd0;
      a_raw       <= 32'd0;
      d           <= 32'd0;
      acc         <= 64'd0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            cnt   <= 5'd0;
            op_q  <= op;
            a_raw <= operand_a;
            sa    <= operand_a[31];
            sb    <= operand_b[31];
            acc   <= {32'd0, a_mag};
            d     <= b_mag;
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end
        CALC: begin
          acc <= next_acc;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          hi          <= hi_fix;
          lo          <= lo_fix;
          done        <= 1'b1;
          div_by_zero <= dz;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports named clock and reset.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- operand_a  in  32  rs value: multiplicand or dividend
- operand_b  in  32  rt value: multiplier or divisor
- mthi  in  1  write wr_data to hi
- mtlo  in  1  write wr_data to lo
- wr_data  in  32  rs value for mthi/mtlo
- busy  out  1  high while state is not IDLE
- done  out  1  one-cycle pulse; hi/lo hold the new result
- div_by_zero  out  1  one-cycle pulse with done when a div/divu had divisor 0
- hi  out  32  HI register
- lo  out  32  LO register

Function
REQ-003 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-004 IDLE -> CALC when start=1; op and operand magnitudes latched; 5-bit iteration counter cleared.
REQ-005 CALC SHALL perform exactly one iteration per cycle for 32 cycles; counter wraps 31 -> 0, then CALC -> FIX.
REQ-006 FIX SHALL last one cycle: sign correction, hi/lo write, done=1, then FIX -> IDLE.
REQ-007 Latency: start sampled at edge k; hi/lo/done update at edge k+33; busy high after edge k through edge k+33 (33 cycles).
REQ-008 Multiply: 32-step shift-add on unsigned magnitudes into a 64-bit product; {hi,lo} = product.
REQ-009 mult (signed): magnitudes from two's complement; 64-bit product negated in FIX when sign(a)^sign(b)=1.
REQ-010 Divide: 32-step restoring division on magnitudes; lo=quotient, hi=remainder.
REQ-011 div (signed): truncate toward zero; quotient negated if sign(a)^sign(b); remainder takes sign of dividend.
REQ-012 div 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0x00000000 (wrap, no flag).
REQ-013 Divisor 0 (div or divu): latency unchanged; at FIX hi=original operand_a, lo=0xFFFFFFFF, div_by_zero=1 with done.
REQ-014 start while busy SHALL be ignored; the in-flight operation is unaffected.
REQ-015 mthi/mtlo SHALL write at the next edge only in IDLE with start=0; ignored while busy.
REQ-016 start and mthi/mtlo together in IDLE: start wins; the writes are dropped.
REQ-017 mthi and mtlo together: both hi and lo get wr_data.
REQ-018 hi/lo SHALL change only at FIX or on a legal mthi/mtlo write; they hold otherwise, including during CALC.
REQ-019 done and div_by_zero SHALL be registered and high for exactly one cycle per completed operation.
REQ-020 Back-to-back: start may be accepted at edge k+34 (first IDLE cycle after done).

Reset
REQ-021 While reset=1, asynchronously: state=IDLE, counter=0, hi=lo=0, busy=done=div_by_zero=0.
REQ-022 Reset mid-CALC or mid-FIX SHALL discard the operation; no done follows.

Verification
REQ-023 mult a=0xFFFFFFFD (-3), b=7 -> done at edge k+33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles.
REQ-024 multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-025 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-026 divu a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF, div_by_zero=1 for one cycle with done.
REQ-027 Ignored and legal writes:
- start and mthi asserted during CALC -> result unchanged, no second operation.
- mthi in IDLE with wr_data=0x1234 -> hi=0x00001234, lo held.
- start+mtlo together in IDLE -> lo not written.
REQ-028 reset pulsed in the 10th CALC cycle -> busy=0, hi=lo=0 immediately; no done pulse in the next 40 cycles.
